// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op and FSM state encodings,
// default latencies and small op-classification helpers.
// Latency: n/a (definitions only). Backpressure: n/a.
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the resource for multiple cycles (MULT..DIVU).
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage to multiply/divide scheduler bundle: op request, D-stage usage hint,
// and the busy/stall/HI/LO responses. master = pipeline side, slave = scheduler.
// Latency: n/a (wiring only). Backpressure: stall_md freezes the D stage.
interface md_sched_if;
    logic        start_E;    // valid MD op in E this cycle
    logic [2:0]  md_op_E;    // op encoding (md_op_e)
    logic [31:0] A_E;        // rs operand / mthi-mtlo data
    logic [31:0] B_E;        // rt operand
    logic        md_use_D;   // D-stage instruction touches the MD unit
    logic        busy;       // op in progress
    logic        stall_md;   // freeze D stage
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start_E, md_op_E, A_E, B_E, md_use_D,
        input  busy, stall_md, HI, LO
    );

    modport slave (
        input  start_E, md_op_E, A_E, B_E, md_use_D,
        output busy, stall_md, HI, LO
    );
endinterface

// File: rtl/md_sched_arith.sv
// Combinational 64-bit multiply/divide result for MULT/MULTU/DIV/DIVU.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_op/i_a/i_b in; o_hi/o_lo result; o_div_zero flags a zero divisor on DIV/DIVU.
module md_sched_arith
    import md_sched_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic        w_neg_q;
    logic        w_neg_r;

    // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide is done on magnitudes, then signs are restored: quotient truncates
    // toward zero and remainder follows the dividend. 0x80000000 / -1 falls out naturally
    // as magnitude 0x80000000 negated back to 0x80000000 with remainder 0.
    assign w_signed_div = (i_op == MD_DIV);
    assign w_mag_a      = (w_signed_div && i_a[31]) ? (~i_a + 32'd1) : i_a;
    assign w_mag_b      = (w_signed_div && i_b[31]) ? (~i_b + 32'd1) : i_b;
    assign o_div_zero   = is_div_op(i_op) && (i_b == 32'd0);
    // Keep the divider operand non-zero so the result is always defined; it is discarded anyway.
    assign w_divisor    = (i_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag      = w_mag_a / w_divisor;
    assign w_r_mag      = w_mag_a % w_divisor;
    assign w_neg_q      = w_signed_div && (i_a[31] ^ i_b[31]);
    assign w_neg_r      = w_signed_div && i_a[31];

    always_comb begin
        o_hi = 32'd0;
        o_lo = 32'd0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV, MD_DIVU: begin
                o_lo = w_neg_q ? (~w_q_mag + 32'd1) : w_q_mag;
                o_hi = w_neg_r ? (~w_r_mag + 32'd1) : w_r_mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: accepts MD ops from E, holds the resource busy for N cycles,
// then commits HI/LO; MTHI/MTLO write HI/LO directly at the next edge.
// Latency: MULT* = MULT_CYCLES, DIV* = DIV_CYCLES edges to HI/LO; MTHI/MTLO 1 edge.
// Backpressure: stall_md freezes D while busy or while an op is starting and D uses the unit.
// Ports: i_clk, i_reset (sync, active-high), md_if (slave side of md_sched_if).
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic      i_clk,
    input  logic      i_reset,
    md_sched_if.slave md_if
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Counter only ever holds N-1, so clog2(N) bits are enough.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_shadow_hi;
    logic [31:0]      r_shadow_lo;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_start_arith;
    logic             w_launch;
    logic             w_commit;
    logic             w_wr_hi;
    logic             w_wr_lo;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;
    logic             w_busy;

    md_sched_arith u_arith (
        .i_op       (md_if.md_op_E),
        .i_a        (md_if.A_E),
        .i_b        (md_if.B_E),
        .o_hi       (w_res_hi),
        .o_lo       (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    assign w_start_arith = md_if.start_E && is_arith_op(md_if.md_op_E);

    // Next-state and control decode. Any start_E seen in RUN is dropped on the floor;
    // the pipeline cannot legally present one because stall_md is up.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_arith) begin
                    w_launch    = 1'b1;
                    w_cnt_nxt   = is_div_op(md_if.md_op_E) ? DIV_LOAD : MULT_LOAD;
                    w_state_nxt = ST_RUN;
                end else if (md_if.start_E && (md_if.md_op_E == MD_MTHI)) begin
                    w_wr_hi = 1'b1;
                end else if (md_if.start_E && (md_if.md_op_E == MD_MTLO)) begin
                    w_wr_lo = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Result is captured at launch so operands need not be held for the whole op.
    // A zero divisor captures the current HI/LO, making the later commit a no-op.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow_hi <= 32'd0;
            r_shadow_lo <= 32'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            if (w_launch) begin
                r_shadow_hi <= w_div_zero ? r_hi : w_res_hi;
                r_shadow_lo <= w_div_zero ? r_lo : w_res_lo;
            end
            if (w_commit) begin
                r_hi <= r_shadow_hi;
                r_lo <= r_shadow_lo;
            end else begin
                if (w_wr_hi) r_hi <= md_if.A_E;
                if (w_wr_lo) r_lo <= md_if.A_E;
            end
        end
    end

    assign w_busy         = (r_state == ST_RUN);
    assign md_if.busy     = w_busy;
    // Purely from current inputs and local state so D can freeze in the same cycle.
    assign md_if.stall_md = md_if.md_use_D && (w_busy || w_start_arith);
    assign md_if.HI       = r_hi;
    assign md_if.LO       = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched: driver issues ops and queues expected results
// from a behavioural model; a monitor checks hold/commit/latency when busy falls.
// Latency/backpressure: bench only.
module tb_md_sched;
    import md_sched_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;
    exp_t exp_q[$];

    md_sched_if sif();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .md_if   (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred that should not", name);
    endtask

    // Architectural result of one op given the current HI/LO.
    function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        int sa, sb;
        longint sp;
        longint unsigned ua, ub, up;
        sa = a; sb = b; ua = a; ub = b;
        case (op)
            0: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; end
            1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            2: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    lo = sa / sb; hi = sa % sb;
                end
            end
            3: if (b != 32'd0) begin lo = a / b; hi = a % b; end
            4: hi = a;
            5: lo = a;
            default: ;
        endcase
    endfunction

    task automatic do_arith(input int op, input logic [31:0] a, input logic [31:0] b,
                            input logic use_d, input logic intrude);
        exp_t e;
        logic [31:0] nh, nl;
        logic done;
        nh = ref_hi; nl = ref_lo;
        model(op, a, b, nh, nl);
        e.hi = nh; e.lo = nl; e.old_hi = ref_hi; e.old_lo = ref_lo;
        e.n  = (op >= 2) ? 10 : 5;
        exp_q.push_back(e);
        sif.start_E = 1'b1; sif.md_op_E = op[2:0]; sif.A_E = a; sif.B_E = b; sif.md_use_D = use_d;
        #1;
        check("stall_start", sif.stall_md, use_d);
        @(negedge clk);
        if (intrude) begin
            // Illegal start while RUN: must be ignored completely.
            sif.md_op_E = MD_DIV; sif.A_E = $urandom; sif.B_E = $urandom;
        end else begin
            sif.start_E = 1'b0;
        end
        @(negedge clk);
        sif.start_E = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!sif.busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            fail_now("op_timeout");
            exp_q.delete();
        end
        check("stall_after", sif.stall_md, 1'b0);
        sif.md_use_D = 1'b0;
        ref_hi = nh; ref_lo = nl;
    endtask

    // MTHI/MTLO/unknown ops: single-edge effect, never busy or stalling.
    task automatic do_simple(input int op, input logic [31:0] a, input logic use_d);
        sif.start_E = 1'b1; sif.md_op_E = op[2:0]; sif.A_E = a; sif.B_E = $urandom; sif.md_use_D = use_d;
        #1;
        check("stall_simple", sif.stall_md, 1'b0);
        @(negedge clk);
        sif.start_E = 1'b0; sif.md_use_D = 1'b0;
        model(op, a, 32'd0, ref_hi, ref_lo);
        check("simple_hi", sif.HI, ref_hi);
        check("simple_lo", sif.LO, ref_lo);
        check("simple_busy", sif.busy, 1'b0);
    endtask

    // Monitor: pops the scoreboard when busy falls (the commit point).
    initial begin
        logic prev_busy;
        int   blen;
        exp_t e;
        prev_busy = 1'b0;
        blen      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_busy = 1'b0;
                blen      = 0;
            end else begin
                if (sif.busy) begin
                    blen++;
                    check("stall_busy", sif.stall_md, sif.md_use_D);
                    if (exp_q.size() == 0) begin
                        fail_now("busy_without_op");
                    end else begin
                        check("hold_hi", sif.HI, exp_q[0].old_hi);
                        check("hold_lo", sif.LO, exp_q[0].old_lo);
                    end
                end else if (prev_busy) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_commit");
                    end else begin
                        e = exp_q.pop_front();
                        check("busy_cycles", blen, e.n);
                        check("commit_hi", sif.HI, e.hi);
                        check("commit_lo", sif.LO, e.lo);
                    end
                    blen = 0;
                end
                prev_busy = sif.busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int op, sel;
        errors = 0; checks = 0;
        ref_hi = 32'd0; ref_lo = 32'd0;
        reset = 1'b1;
        sif.start_E = 1'b0; sif.md_op_E = 3'd0; sif.A_E = 32'd0; sif.B_E = 32'd0; sif.md_use_D = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", sif.busy, 1'b0);
        check("rst_hi", sif.HI, 32'd0);
        check("rst_lo", sif.LO, 32'd0);
        check("rst_stall", sif.stall_md, 1'b0);

        // Directed cases with hand-derived results.
        do_arith(0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        check("mult_hi", sif.HI, 32'hFFFF_FFFF);
        check("mult_lo", sif.LO, 32'hFFFF_FFFA);
        do_arith(1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("multu_hi", sif.HI, 32'd1);
        check("multu_lo", sif.LO, 32'hFFFF_FFFE);
        do_arith(2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        check("div_lo", sif.LO, 32'hFFFF_FFFD);
        check("div_hi", sif.HI, 32'hFFFF_FFFF);
        do_arith(3, 32'd7, 32'd0, 1'b1, 1'b0);
        check("divu0_hi", sif.HI, 32'hFFFF_FFFF);
        check("divu0_lo", sif.LO, 32'hFFFF_FFFD);
        do_simple(4, 32'h0000_1234, 1'b1);
        check("mthi_hi", sif.HI, 32'h0000_1234);
        do_simple(5, 32'h0000_ABCD, 1'b0);
        do_simple(6, 32'hDEAD_BEEF, 1'b1);
        do_simple(7, 32'hCAFE_F00D, 1'b0);
        do_arith(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("divovf_lo", sif.LO, 32'h8000_0000);
        check("divovf_hi", sif.HI, 32'd0);

        // Reset in the middle of a DIV: aborts, clears, never commits.
        do_simple(4, 32'h5555_AAAA, 1'b0);
        exp_q.push_back('{hi: 32'd0, lo: 32'd0, old_hi: ref_hi, old_lo: ref_lo, n: 10});
        sif.start_E = 1'b1; sif.md_op_E = MD_DIV; sif.A_E = 32'd100; sif.B_E = 32'd7;
        @(negedge clk);
        sif.start_E = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", sif.busy, 1'b0);
        check("midrst_hi", sif.HI, 32'd0);
        check("midrst_lo", sif.LO, 32'd0);
        exp_q.delete();
        reset = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0;
        repeat (15) @(negedge clk);
        check("postrst_busy", sif.busy, 1'b0);
        check("postrst_hi", sif.HI, 32'd0);
        check("postrst_lo", sif.LO, 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            op  = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = $urandom_range(0, 50) - 25; b = $urandom_range(0, 10) - 5; end
            if (op <= 3) do_arith(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            else do_simple(op, a, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) fail_now("leftover_expect");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
